// File: rtl/axi_ar_rr_sched.sv
// Read-address scheduler: round-robin AR arbitration with per-requester outstanding
// throttling, ID-prefix tagging, and combinational R routing by that prefix.
module axi_ar_rr_sched #(
  parameter int NumReq    = 4,
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int MaxTxns   = 8,
  localparam int SelW     = $clog2(NumReq),
  localparam int CntW     = $clog2(MaxTxns + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_ar_valid_i,
  output logic [NumReq-1:0]            req_ar_ready_o,
  input  logic [NumReq*IdWidth-1:0]    req_ar_id_i,
  input  logic [NumReq*AddrWidth-1:0]  req_ar_addr_i,
  input  logic [NumReq*8-1:0]          req_ar_len_i,
  output logic                         mst_ar_valid_o,
  input  logic                         mst_ar_ready_i,
  output logic [IdWidth+SelW-1:0]      mst_ar_id_o,
  output logic [AddrWidth-1:0]         mst_ar_addr_o,
  output logic [7:0]                   mst_ar_len_o,
  input  logic                         mst_r_valid_i,
  output logic                         mst_r_ready_o,
  input  logic [IdWidth+SelW-1:0]      mst_r_id_i,
  input  logic [DataWidth-1:0]         mst_r_data_i,
  input  logic [1:0]                   mst_r_resp_i,
  input  logic                         mst_r_last_i,
  output logic [NumReq-1:0]            req_r_valid_o,
  input  logic [NumReq-1:0]            req_r_ready_i,
  output logic [IdWidth-1:0]           req_r_id_o,
  output logic [DataWidth-1:0]         req_r_data_o,
  output logic [1:0]                   req_r_resp_o,
  output logic                         req_r_last_o,
  output logic                         idle_o,
  output logic                         err_o
);

  typedef enum logic {ST_EMPTY, ST_FULL} ar_state_e;

  ar_state_e              state;
  logic [SelW-1:0]        ptr;
  logic [CntW-1:0]        cnt [NumReq];
  logic [IdWidth+SelW-1:0] ar_id_q;
  logic [AddrWidth-1:0]   ar_addr_q;
  logic [7:0]             ar_len_q;
  logic                   err_q;

  logic                   can_load;
  logic                   found;
  logic                   grant;
  logic [SelW-1:0]        win;
  logic [NumReq-1:0]      eligible;
  logic [IdWidth-1:0]     win_id;
  logic [AddrWidth-1:0]   win_addr;
  logic [7:0]             win_len;
  logic [SelW-1:0]        ptr_next;

  logic [SelW-1:0]        sel;
  logic                   sel_ok;
  logic                   sel_cnt_zero;
  logic                   r_ready;
  logic                   r_last_hs;
  logic                   cnt_busy;

  // Arbitration: first eligible index at or after ptr, wrapping at NumReq.
  always_comb begin
    int unsigned idx;
    can_load = (state == ST_EMPTY) || mst_ar_ready_i;
    for (int unsigned i = 0; i < NumReq; i++) begin
      eligible[i] = req_ar_valid_i[i] && (cnt[i] < CntW'(MaxTxns));
    end
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = {{(32-SelW){1'b0}}, ptr} + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = SelW'(idx);
      end
    end
    grant          = can_load && found;
    req_ar_ready_o = '0;
    win_id         = '0;
    win_addr       = '0;
    win_len        = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (SelW'(i) == win) begin
        req_ar_ready_o[i] = grant;
        win_id            = req_ar_id_i[i*IdWidth +: IdWidth];
        win_addr          = req_ar_addr_i[i*AddrWidth +: AddrWidth];
        win_len           = req_ar_len_i[i*8 +: 8];
      end
    end
    ptr_next = (win == SelW'(NumReq - 1)) ? '0 : win + 1'b1;
  end

  // R routing; an unmatched prefix leaves ready high so the beat is dropped.
  always_comb begin
    sel           = mst_r_id_i[IdWidth+SelW-1:IdWidth];
    sel_ok        = 1'b0;
    sel_cnt_zero  = 1'b0;
    r_ready       = 1'b1;
    req_r_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (SelW'(i) == sel) begin
        sel_ok           = 1'b1;
        sel_cnt_zero     = (cnt[i] == '0);
        r_ready          = req_r_ready_i[i];
        req_r_valid_o[i] = mst_r_valid_i;
      end
    end
    r_last_hs = mst_r_valid_i && r_ready && mst_r_last_i;
    cnt_busy  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cnt[i] != '0) cnt_busy = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_EMPTY;
      ptr       <= '0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) cnt[i] <= '0;
    end else begin
      if (grant) begin
        state     <= ST_FULL;
        ar_id_q   <= {win, win_id};
        ar_addr_q <= win_addr;
        ar_len_q  <= win_len;
        ptr       <= ptr_next;
      end else if (mst_ar_ready_i) begin
        state <= ST_EMPTY;
      end
      // A last beat against an empty counter is an error and does not decrement.
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (grant && win == SelW'(i)) begin
          if (!(r_last_hs && sel == SelW'(i) && cnt[i] != '0)) cnt[i] <= cnt[i] + 1'b1;
        end else if (r_last_hs && sel == SelW'(i) && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if ((mst_r_valid_i && !sel_ok) || (r_last_hs && sel_ok && sel_cnt_zero)) err_q <= 1'b1;
    end
  end

  assign mst_ar_valid_o = (state == ST_FULL);
  assign mst_ar_id_o    = ar_id_q;
  assign mst_ar_addr_o  = ar_addr_q;
  assign mst_ar_len_o   = ar_len_q;
  assign mst_r_ready_o  = r_ready;
  assign req_r_id_o     = mst_r_id_i[IdWidth-1:0];
  assign req_r_data_o   = mst_r_data_i;
  assign req_r_resp_o   = mst_r_resp_i;
  assign req_r_last_o   = mst_r_last_i;
  assign idle_o         = (state == ST_EMPTY) && !cnt_busy;
  assign err_o          = err_q;

endmodule
